// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared constants and helpers for the 7-segment scan controller.
//   SEG_BLANK      : all segments off (segments are active-low)
//   DP_BIT         : bit position of the decimal point in the segment byte
//   HEX_SEG_TABLE  : hex nibble -> {a,b,c,d,e,f,g,1}, entry 0 in the low byte
//   hex_to_seg()   : table lookup with optional decimal point
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 0;

    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
        logic [7:0] seg;
        seg = HEX_SEG_TABLE[nibble];
        if (dp) begin
            seg[DP_BIT] = 1'b0;
        end
        return seg;
    endfunction

endpackage

// File: rtl/fnd_seg_encode.sv
// -----------------------------------------------------------------------------
// fnd_seg_encode
// Combinational segment encoder for one digit.
//   nibble : hex value to show
//   dp     : 1 = light the decimal point
//   blank  : 1 = force all segments off
//   seg    : {a,b,c,d,e,f,g,dp}, active-low
// -----------------------------------------------------------------------------
module fnd_seg_encode
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble, dp);
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl
// Multiplexed common-anode 7-segment scan controller with hex decode,
// per-digit dp/blank/blink masks, PWM dimming and frame-aligned shadow loading.
//   CLK, RESET  : clock, asynchronous active-high reset
//   digit_data  : packed nibbles, most significant nibble = digit 0 (leftmost)
//   dp_mask     : decimal point enables, MSB = digit 0
//   blank_mask  : digit dark, MSB = digit 0
//   blink_mask  : digit blinks, MSB = digit 0
//   brightness  : 0 = dimmest, all-ones = 100% duty
//   load        : strobe capturing all of the above
//   pending     : captured set waiting for the next frame boundary
//   frame_tick  : one-cycle pulse the cycle after each frame boundary
//   FND_COM     : one-hot digit enable, active-high, MSB = digit 0
//   FND_DATA    : segments {a,b,c,d,e,f,g,dp}, active-low
// -----------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_BITS    = 16,
    parameter int DIM_BITS     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [DIM_BITS-1:0]     brightness,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   FND_COM,
    output logic [7:0]              FND_DATA
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(BLINK_FRAMES - 1);

    logic [SCAN_BITS-1:0]    slot_q, slot_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [FRM_W-1:0]        frame_q, frame_d;
    logic                    blink_ph_q, blink_ph_d;
    logic                    pending_q, pending_d;
    logic                    tick_q, tick_d;
    logic [NUM_DIGITS-1:0]   com_q, com_d;
    logic [7:0]              seg_q, seg_d;

    logic [4*NUM_DIGITS-1:0] hold_data_q, hold_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   hold_blank_q, hold_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   hold_blink_q, hold_blink_d, act_blink_q, act_blink_d;
    logic [DIM_BITS-1:0]     hold_bright_q, hold_bright_d, act_bright_q, act_bright_d;

    logic                    slot_wrap, boundary, dim_on;
    logic [DIM_BITS-1:0]     dim_phase;
    logic [3:0]              sel_nibble;
    logic                    sel_dp, sel_blank;
    logic [NUM_DIGITS-1:0]   sel_com;
    logic [7:0]              enc_seg;

    // Scan counters, blink phase and the hold/active shadow registers.
    always_comb begin
        slot_wrap = &slot_q;
        boundary  = slot_wrap && (digit_q == LAST_DIGIT);

        slot_d  = slot_q + SCAN_BITS'(1);
        digit_d = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
        end

        frame_d    = frame_q;
        blink_ph_d = blink_ph_q;
        if (boundary) begin
            if (frame_q == LAST_FRAME) begin
                frame_d    = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end

        tick_d        = boundary;
        pending_d     = pending_q;
        hold_data_d   = hold_data_q;
        hold_dp_d     = hold_dp_q;
        hold_blank_d  = hold_blank_q;
        hold_blink_d  = hold_blink_q;
        hold_bright_d = hold_bright_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
        act_blink_d   = act_blink_q;
        act_bright_d  = act_bright_q;

        if (load) begin
            hold_data_d   = digit_data;
            hold_dp_d     = dp_mask;
            hold_blank_d  = blank_mask;
            hold_blink_d  = blink_mask;
            hold_bright_d = brightness;
        end

        if (boundary && load) begin
            // A load landing on the boundary goes straight to the display.
            act_data_d   = digit_data;
            act_dp_d     = dp_mask;
            act_blank_d  = blank_mask;
            act_blink_d  = blink_mask;
            act_bright_d = brightness;
            pending_d    = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            act_data_d   = hold_data_q;
            act_dp_d     = hold_dp_q;
            act_blank_d  = hold_blank_q;
            act_blink_d  = hold_blink_q;
            act_bright_d = hold_bright_q;
            pending_d    = 1'b0;
        end
    end

    // Digit selection; index 0 lives in the most significant field of each mask.
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b1;
        sel_com    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
                sel_nibble                = act_data_q[4*(NUM_DIGITS-1-i) +: 4];
                sel_dp                    = act_dp_q[NUM_DIGITS-1-i];
                sel_blank                 = act_blank_q[NUM_DIGITS-1-i]
                                          | (blink_ph_q & act_blink_q[NUM_DIGITS-1-i]);
                sel_com[NUM_DIGITS-1-i]   = 1'b1;
            end
        end
    end

    fnd_seg_encode u_seg_encode (
        .nibble (sel_nibble),
        .dp     (sel_dp),
        .blank  (sel_blank),
        .seg    (enc_seg)
    );

    // PWM: the slot's top bits act as a ramp compared against brightness.
    always_comb begin
        dim_phase = slot_q[SCAN_BITS-1 -: DIM_BITS];
        dim_on    = (dim_phase <= act_bright_q);
        com_d     = dim_on ? sel_com : '0;
        seg_d     = dim_on ? enc_seg : SEG_BLANK;
    end

    // Register stage: everything above becomes visible one cycle later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_q        <= '0;
            digit_q       <= '0;
            frame_q       <= '0;
            blink_ph_q    <= 1'b0;
            pending_q     <= 1'b0;
            tick_q        <= 1'b0;
            com_q         <= '0;
            seg_q         <= SEG_BLANK;
            hold_data_q   <= '0;
            hold_dp_q     <= '0;
            hold_blank_q  <= '1;
            hold_blink_q  <= '0;
            hold_bright_q <= '0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            act_blink_q   <= '0;
            act_bright_q  <= '0;
        end else begin
            slot_q        <= slot_d;
            digit_q       <= digit_d;
            frame_q       <= frame_d;
            blink_ph_q    <= blink_ph_d;
            pending_q     <= pending_d;
            tick_q        <= tick_d;
            com_q         <= com_d;
            seg_q         <= seg_d;
            hold_data_q   <= hold_data_d;
            hold_dp_q     <= hold_dp_d;
            hold_blank_q  <= hold_blank_d;
            hold_blink_q  <= hold_blink_d;
            hold_bright_q <= hold_bright_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            act_blink_q   <= act_blink_d;
            act_bright_q  <= act_bright_d;
        end
    end

    assign pending    = pending_q;
    assign frame_tick = tick_q;
    assign FND_COM    = com_q;
    assign FND_DATA   = seg_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_ctrl
// Scoreboard bench for fnd_scan_ctrl (4 digits, 16-cycle slots, 64-cycle
// frames, blink every 2 frames). A frame-level reference model pushes the
// expected outputs for every clock into a queue; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_fnd_scan_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [1:0]  bright;
    } cfg_t;

    typedef struct packed {
        logic [3:0] com;
        logic [7:0] seg;
        logic       tick;
        logic       pend;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic [15:0] digit_data;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [1:0]  brightness;
    logic        load;
    logic        pending;
    logic        frame_tick;
    logic [3:0]  FND_COM;
    logic [7:0]  FND_DATA;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    localparam cfg_t RST_CFG = '{data: 16'h0000, dp: 4'h0, blank: 4'hF, blink: 4'h0, bright: 2'd0};

    cfg_t act_cfg;
    cfg_t nxt_cfg;
    logic loaded;
    exp_t exp_q [$];

    fnd_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_BITS    (4),
        .DIM_BITS     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .digit_data (digit_data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .load       (load),
        .pending    (pending),
        .frame_tick (frame_tick),
        .FND_COM    (FND_COM),
        .FND_DATA   (FND_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic cfg_t mk_cfg(input logic [15:0] d, input logic [3:0] dp,
                                    input logic [3:0] bl, input logic [3:0] bk,
                                    input logic [1:0] br);
        cfg_t c;
        c.data = d; c.dp = dp; c.blank = bl; c.blink = bk; c.bright = br;
        return c;
    endfunction

    // What the display shows while the scan sits at cycle n since reset.
    function automatic exp_t model_out(input cfg_t c, input int n);
        exp_t e;
        int   slot, dig, frame, pos;
        logic off;
        slot  = n % 16;
        dig   = (n / 16) % 4;
        frame = n / 64;
        pos   = 3 - dig;
        e.tick = 1'b0;
        e.pend = 1'b0;
        if ((slot / 4) <= int'(c.bright)) begin
            e.com = 4'(1 << pos);
            off   = c.blank[pos] | ((((frame / 2) % 2) == 1) & c.blink[pos]);
            if (off) begin
                e.seg = 8'hFF;
            end else begin
                e.seg = seg_tab[c.data[4*pos +: 4]];
                if (c.dp[pos]) e.seg = e.seg & 8'hFE;
            end
        end else begin
            e.com = 4'b0000;
            e.seg = 8'hFF;
        end
        return e;
    endfunction

    // Reference model: a set loaded during frame f is shown from frame f+1 on.
    always @(posedge CLK or posedge RESET) begin
        exp_t e;
        if (RESET) begin
            cyc     = 0;
            act_cfg = RST_CFG;
            nxt_cfg = RST_CFG;
            loaded  = 1'b0;
            exp_q.delete();
        end else begin
            e = model_out(act_cfg, cyc);
            if (load) begin
                nxt_cfg = mk_cfg(digit_data, dp_mask, blank_mask, blink_mask, brightness);
                loaded  = 1'b1;
            end
            if ((cyc % 64) == 63) begin
                if (loaded) act_cfg = nxt_cfg;
                loaded = 1'b0;
            end
            e.tick = ((cyc % 64) == 63);
            e.pend = loaded;
            exp_q.push_back(e);
            cyc = cyc + 1;
        end
    end

    // Monitor: one expected entry per clock, compared mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("display", {20'h0, FND_COM, FND_DATA}, {20'h0, e.com, e.seg});
            check("control", {30'h0, frame_tick, pending}, {30'h0, e.tick, e.pend});
        end
    end

    task automatic apply_cfg(input cfg_t c);
        digit_data = c.data;
        dp_mask    = c.dp;
        blank_mask = c.blank;
        blink_mask = c.blink;
        brightness = c.bright;
    endtask

    // Load c when the next sampled cycle sits at frame position phase (-1 = now).
    task automatic do_load(input cfg_t c, input int phase);
        @(negedge CLK);
        if (phase >= 0) begin
            for (int k = 0; k < 64 && (cyc % 64) != phase; k++) @(negedge CLK);
        end
        apply_cfg(c);
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        apply_cfg(cfg_t'($urandom));
    endtask

    task automatic check_reset_outputs();
        check("rst_com",  {28'h0, FND_COM},  32'h0);
        check("rst_data", {24'h0, FND_DATA}, 32'hFF);
        check("rst_pend", {31'h0, pending},  32'h0);
        check("rst_tick", {31'h0, frame_tick}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c;
        RESET = 1'b1;
        load  = 1'b0;
        apply_cfg(RST_CFG);
        #12;
        check_reset_outputs();
        @(negedge CLK);
        RESET = 1'b0;

        // Idle: dark display, plain scan
        repeat (130) @(negedge CLK);

        // Basic load with decimal point
        do_load(mk_cfg(16'h12AF, 4'b0010, 4'b0000, 4'b0000, 2'd3), 5);
        repeat (140) @(negedge CLK);

        // Two loads in one frame: last one wins
        do_load(mk_cfg(16'h3C5E, 4'b1001, 4'b0000, 4'b0000, 2'd3), 10);
        do_load(mk_cfg(16'h8888, 4'b0000, 4'b0000, 4'b0000, 2'd3), 40);
        repeat (140) @(negedge CLK);

        // Dimming levels
        do_load(mk_cfg(16'h4567, 4'b0000, 4'b0000, 4'b0000, 2'd0), -1);
        repeat (140) @(negedge CLK);
        do_load(mk_cfg(16'h9BDF, 4'b0100, 4'b0000, 4'b0000, 2'd1), -1);
        repeat (140) @(negedge CLK);

        // Blink on the rightmost digit over several blink periods
        do_load(mk_cfg(16'h0000, 4'b0000, 4'b0000, 4'b0001, 2'd3), -1);
        repeat (520) @(negedge CLK);

        // Load landing exactly on a frame boundary
        do_load(mk_cfg(16'hA5C3, 4'b1111, 4'b0100, 4'b0000, 2'd2), 63);
        repeat (70) @(negedge CLK);

        // Randomized loads, some aligned to the boundary cycle
        for (int it = 0; it < 30; it++) begin
            c = cfg_t'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                do_load(c, 63);
            end else begin
                repeat ($urandom_range(1, 90)) @(negedge CLK);
                do_load(c, -1);
            end
        end
        repeat (140) @(negedge CLK);

        // Reset in the middle of a slot with a load pending
        do_load(mk_cfg(16'h1234, 4'b0000, 4'b0000, 4'b0000, 2'd3), 20);
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (140) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
